// File: rtl/soc_input_conditioner.sv
// Input conditioner ahead of the accumulator SoC: synchronizes and debounces the accumulate pushbutton and the slide switches.
// Build option: define SW_DEBOUNCE_EN to debounce the switch vector; otherwise the switches are only 2-FF synchronized.
module soc_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_WIDTH        = 10,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                key_acc_n,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic                acc_wire_export,
    output logic                acc_pulse,
    output logic [SW_WIDTH-1:0] sw_wire_export,
    output logic [1:0]          key_state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_HELD      = 2'd2,
        ST_DISARMING = 2'd3
    } key_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                r_key_sync1;
    logic                r_key_sync2;
    logic [SW_WIDTH-1:0] r_sw_sync1;
    logic [SW_WIDTH-1:0] r_sw_sync2;
    logic                w_key_s;
    logic [SW_WIDTH-1:0] w_sw_s;

    key_state_t          r_state;
    key_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_kcnt;
    logic [CNT_W-1:0]    w_kcnt_nxt;
    logic                r_acc_wire;
    logic                r_acc_pulse;
    logic                w_key_down;

    // Key synchronizer idles at 1 (released) so reset never looks like a press.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_key_sync1 <= 1'b1;
            r_key_sync2 <= 1'b1;
            r_sw_sync1  <= '0;
            r_sw_sync2  <= '0;
        end else begin
            r_key_sync1 <= key_acc_n;
            r_key_sync2 <= r_key_sync1;
            r_sw_sync1  <= sw_raw;
            r_sw_sync2  <= r_sw_sync1;
        end
    end

    assign w_key_s = ~r_key_sync2;
    assign w_sw_s  = r_sw_sync2;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= ST_IDLE;
            r_kcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_kcnt  <= w_kcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kcnt_nxt  = r_kcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_key_s) begin
                    w_state_nxt = ST_ARMING;
                    w_kcnt_nxt  = CNT_ONE;
                end else begin
                    w_kcnt_nxt  = '0;
                end
            end
            ST_ARMING: begin
                if (!w_key_s) begin
                    w_state_nxt = ST_IDLE;
                    w_kcnt_nxt  = '0;
                end else if (r_kcnt == CNT_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_kcnt_nxt  = '0;
                end else begin
                    w_kcnt_nxt  = r_kcnt + CNT_ONE;
                end
            end
            // HELD never counts, so a key held indefinitely cannot wrap the counter.
            ST_HELD: begin
                if (!w_key_s) begin
                    w_state_nxt = ST_DISARMING;
                    w_kcnt_nxt  = CNT_ONE;
                end
            end
            ST_DISARMING: begin
                if (w_key_s) begin
                    w_state_nxt = ST_HELD;
                    w_kcnt_nxt  = '0;
                end else if (r_kcnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_kcnt_nxt  = '0;
                end else begin
                    w_kcnt_nxt  = r_kcnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_kcnt_nxt  = '0;
            end
        endcase
    end

    assign w_key_down = (r_state == ST_HELD) || (r_state == ST_DISARMING);

    // The pulse fires on the cycle the level first rises; DISARMING->HELD keeps the level high so it cannot re-fire.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_acc_wire  <= 1'b0;
            r_acc_pulse <= 1'b0;
        end else begin
            r_acc_wire  <= w_key_down;
            r_acc_pulse <= w_key_down && !r_acc_wire;
        end
    end

    assign acc_wire_export = r_acc_wire;
    assign acc_pulse       = r_acc_pulse;
    assign key_state_dbg   = r_state;

`ifdef SW_DEBOUNCE_EN
    logic [SW_WIDTH-1:0] r_sw_p;
    logic [CNT_W-1:0]    r_scnt;
    logic [SW_WIDTH-1:0] r_sw_out;

    // One window for the whole vector: any bit moving restarts it, so bits always update together.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sw_p   <= '0;
            r_scnt   <= '0;
            r_sw_out <= '0;
        end else if (w_sw_s != r_sw_p) begin
            r_sw_p   <= w_sw_s;
            r_scnt   <= '0;
        end else if (r_scnt == CNT_LAST) begin
            r_sw_out <= w_sw_s;
        end else begin
            r_scnt   <= r_scnt + CNT_ONE;
        end
    end

    assign sw_wire_export = r_sw_out;
`else
    assign sw_wire_export = w_sw_s;
`endif

endmodule
